// File: rtl/raycaster_pkg.sv
// Shared raycaster types: camera pose, screen geometry and the frame scheduler states.
package raycaster_pkg;

    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 240;

    // Q8.8 fixed point; pos_x occupies the most significant 16 bits.
    typedef struct packed {
        logic signed [15:0] pos_x;
        logic signed [15:0] pos_y;
        logic signed [15:0] dir_x;
        logic signed [15:0] dir_y;
        logic signed [15:0] plane_x;
        logic signed [15:0] plane_y;
    } pose_t;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/ray_scheduler_if.sv
// Ray request channel between the frame scheduler and ray_calculations.
interface ray_scheduler_if #(
    parameter int HCOUNT_W = 9
);
    import raycaster_pkg::*;

    logic                ray_valid_out;
    logic                ray_ready_in;
    logic [HCOUNT_W-1:0] hcount_out;
    pose_t               pose_out;

    modport master (
        output ray_valid_out,
        output hcount_out,
        output pose_out,
        input  ray_ready_in
    );

    modport slave (
        input  ray_valid_out,
        input  hcount_out,
        input  pose_out,
        output ray_ready_in
    );

endinterface

// File: rtl/inflight_counter.sv
// Credit counter for rays in flight: issue counts up, completion counts down.
module inflight_counter #(
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               up,
    input  logic                               down,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]  count,
    output logic                               will_be_full,
    output logic                               underflow
);
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [CW-1:0] count_next;

    // Simultaneous up and down cancel; a lone down at zero is flagged, not wrapped.
    always_comb begin
        count_next = count;
        underflow  = 1'b0;
        if (up && !down) begin
            if (count != CW'(MAX_INFLIGHT))
                count_next = count + 1'b1;
        end else if (down && !up) begin
            if (count == '0)
                underflow = 1'b1;
            else
                count_next = count - 1'b1;
        end
    end

    assign will_be_full = (count_next == CW'(MAX_INFLIGHT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else
            count <= count_next;
    end

endmodule

// File: rtl/ray_scheduler.sv
// Frame sequencer: latches pose on new frame, issues one ray per column under a
// credit limit, and pulses frame_done_out once every column has completed.
module ray_scheduler #(
    parameter int SCREEN_WIDTH = raycaster_pkg::SCREEN_WIDTH,
    parameter int HCOUNT_W     = 9,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                               pixel_clk_in,
    input  logic                               rst_in,
    input  logic                               enable_in,
    input  logic                               new_frame_in,
    input  raycaster_pkg::pose_t               pose_in,
    ray_scheduler_if.master                    ray,
    input  logic                               col_done_in,
    output logic                               busy_out,
    output logic                               frame_done_out,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_out,
    output logic [7:0]                         skip_count_out,
    output logic                               err_out
);
    import raycaster_pkg::*;

    localparam logic [HCOUNT_W-1:0] LAST_COL = HCOUNT_W'(SCREEN_WIDTH - 1);

    sched_state_t state;
    logic         handshake;
    logic         will_be_full;
    logic         underflow;

    assign handshake = ray.ray_valid_out && ray.ray_ready_in;

    inflight_counter #(
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) u_credits (
        .clk          (pixel_clk_in),
        .rst_n        (rst_in),
        .up           (handshake),
        .down         (col_done_in),
        .count        (inflight_out),
        .will_be_full (will_be_full),
        .underflow    (underflow)
    );

    // Valid is registered from the look-ahead credit count; since credits only
    // grow back while waiting, a raised valid can never drop before its handshake.
    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state             <= IDLE;
            ray.ray_valid_out <= 1'b0;
            ray.hcount_out    <= '0;
            ray.pose_out      <= '0;
            busy_out          <= 1'b0;
            frame_done_out    <= 1'b0;
            skip_count_out    <= '0;
            err_out           <= 1'b0;
        end else begin
            frame_done_out <= 1'b0;
            if (underflow)
                err_out <= 1'b1;
            if (new_frame_in && state != IDLE && skip_count_out != 8'hFF)
                skip_count_out <= skip_count_out + 1'b1;

            case (state)
                IDLE: begin
                    if (new_frame_in && enable_in) begin
                        state    <= LATCH;
                        busy_out <= 1'b1;
                    end
                end
                LATCH: begin
                    ray.pose_out      <= pose_in;
                    ray.hcount_out    <= '0;
                    ray.ray_valid_out <= !will_be_full;
                    state             <= ISSUE;
                end
                ISSUE: begin
                    if (handshake && ray.hcount_out == LAST_COL) begin
                        ray.ray_valid_out <= 1'b0;
                        state             <= DRAIN;
                    end else begin
                        if (handshake)
                            ray.hcount_out <= ray.hcount_out + 1'b1;
                        ray.ray_valid_out <= !will_be_full;
                    end
                end
                DRAIN: begin
                    if (inflight_out == '0) begin
                        frame_done_out <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    ray.ray_valid_out <= 1'b0;
                    busy_out          <= 1'b0;
                    state             <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ray_scheduler.sv
// Randomised scoreboard bench for ray_scheduler: column order, pose latching,
// credit accounting, skip counting and error flagging against a reference model.
module tb_ray_scheduler;

    localparam int W    = 320;
    localparam int HW   = 9;
    localparam int MAXI = 16;
    localparam int M_FIXED = 0;
    localparam int M_HOLD  = 1;
    localparam int M_RAND  = 2;

    logic        clk = 1'b0;
    logic        rst_in = 1'b0;
    logic        enable_in = 1'b0;
    logic        new_frame_in = 1'b0;
    logic [95:0] pose_in = '0;
    logic        col_done_in = 1'b0;
    logic        busy_out, frame_done_out, err_out;
    logic [4:0]  inflight_out;
    logic [7:0]  skip_count_out;

    ray_scheduler_if #(.HCOUNT_W(HW)) ray_bus ();

    ray_scheduler #(
        .SCREEN_WIDTH (W),
        .HCOUNT_W     (HW),
        .MAX_INFLIGHT (MAXI)
    ) dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst_in),
        .enable_in      (enable_in),
        .new_frame_in   (new_frame_in),
        .pose_in        (pose_in),
        .ray            (ray_bus),
        .col_done_in    (col_done_in),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out),
        .inflight_out   (inflight_out),
        .skip_count_out (skip_count_out),
        .err_out        (err_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // reference model state
    int          m_inflight = 0;
    int          m_skip = 0;
    bit          m_err = 0;
    int          colq[$];
    int          fd_expected = 0;
    int          frames_done = 0;
    logic [95:0] exp_pose = '0;
    int          start_age = 0;
    bit          prev_wait = 0;
    logic [HW-1:0] prev_h = '0;
    int          max_inflight = 0;
    int          first_hs = 0, last_hs = 0;

    // completion model
    int cyc = 0;
    int pend[$];
    int last_due = 0;
    int held = 0;
    int extra_req = 0;
    int mode = M_FIXED;

    initial forever begin
        @(posedge clk);
        cyc++;
        #2;
        if (!rst_in) begin
            pend.delete();
            last_due = 0;
            col_done_in = 1'b0;
        end else if (pend.size() > 0 && pend[0] <= cyc) begin
            col_done_in = 1'b1;
            pend.delete(0);
        end else if (extra_req > 0) begin
            col_done_in = 1'b1;
            extra_req--;
        end else begin
            col_done_in = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        pose_in = {$urandom, $urandom, $urandom};
    end

    always @(negedge clk) begin
        bit hs;
        int due;
        int col;
        if (!rst_in) begin
            m_inflight = 0; m_err = 0; m_skip = 0;
            colq.delete(); fd_expected = 0; start_age = 0; prev_wait = 0; held = 0;
        end else begin
            chk("inflight", inflight_out, m_inflight);
            chk("err", err_out, m_err);
            chk("skip_count", skip_count_out, m_skip);
            if (inflight_out > max_inflight) max_inflight = inflight_out;
            if (prev_wait) chk("hold_stable", {ray_bus.ray_valid_out, ray_bus.hcount_out}, {1'b1, prev_h});
            if (start_age == 1) begin
                chk("latch_busy", busy_out, 1);
                exp_pose = pose_in;
                start_age = 2;
            end else if (start_age == 2) begin
                chk("first_request", {ray_bus.ray_valid_out, ray_bus.hcount_out}, {1'b1, {HW{1'b0}}});
                chk("pose_latched", ray_bus.pose_out, exp_pose);
                start_age = 0;
            end
            hs = ray_bus.ray_valid_out && ray_bus.ray_ready_in;
            if (hs) begin
                chk("handshake_expected", colq.size() > 0, 1);
                if (colq.size() > 0) begin
                    col = colq.pop_front();
                    chk("hcount", ray_bus.hcount_out, col);
                    chk("pose_stable", ray_bus.pose_out, exp_pose);
                    if (col == 0) first_hs = cyc;
                    if (col == W - 1) begin
                        last_hs = cyc;
                        fd_expected++;
                    end
                end
                if (mode == M_HOLD) begin
                    held++;
                end else begin
                    due = cyc + ((mode == M_FIXED) ? 3 : int'($urandom_range(1, 8)));
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    pend.push_back(due);
                end
            end
            if (frame_done_out) begin
                chk("frame_done_expected", fd_expected > 0, 1);
                if (fd_expected > 0) fd_expected--;
                frames_done++;
            end
            prev_wait = ray_bus.ray_valid_out && !ray_bus.ray_ready_in;
            prev_h    = ray_bus.hcount_out;
            if (hs && !col_done_in) m_inflight++;
            else if (col_done_in && !hs) begin
                if (m_inflight == 0) m_err = 1;
                else m_inflight--;
            end
            if (new_frame_in && busy_out && m_skip < 255) m_skip++;
            if (new_frame_in && enable_in && !busy_out) begin
                colq.delete();
                for (int i = 0; i < W; i++) colq.push_back(i);
                start_age = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        new_frame_in = 1'b1;
        tick();
        new_frame_in = 1'b0;
    endtask

    task automatic wait_done(input int snap, input int limit, input bit rnd);
        bit ok = 0;
        for (int i = 0; i < limit; i++) begin
            if (rnd) ray_bus.ray_ready_in = 1'($urandom_range(0, 1));
            tick();
            if (frames_done > snap) begin
                ok = 1;
                break;
            end
        end
        chk("frame_done_seen", ok, 1);
        repeat (3) tick();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, ray_bus.ray_valid_out, 0);
        chk({tag, "_hcount"}, ray_bus.hcount_out, 0);
        chk({tag, "_pose"}, ray_bus.pose_out, 0);
        chk({tag, "_busy"}, busy_out, 0);
        chk({tag, "_done"}, frame_done_out, 0);
        chk({tag, "_inflight"}, inflight_out, 0);
        chk({tag, "_skip"}, skip_count_out, 0);
        chk({tag, "_err"}, err_out, 0);
    endtask

    initial begin
        int fs;
        bit found;
        ray_bus.ray_ready_in = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_in = 1'b1;
        tick();

        // abandon a frame mid-issue with an asynchronous reset
        enable_in = 1'b1; ray_bus.ray_ready_in = 1'b1; mode = M_FIXED;
        pulse();
        for (int i = 0; i < 300; i++) begin
            tick();
            if (ray_bus.hcount_out == 100) break;
        end
        chk("reach_hcount100", ray_bus.hcount_out, 100);
        #2 rst_in = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (2) @(posedge clk);
        #3 rst_in = 1'b1;
        tick();

        // full frame, completions 3 cycles after each handshake
        max_inflight = 0;
        fs = frames_done;
        pulse();
        wait_done(fs, 1000, 0);
        chk("max_inflight_le4", max_inflight <= 4, 1);
        chk("issue_span", last_hs - first_hs, W - 1);

        // credits exhausted with completions withheld
        mode = M_HOLD;
        fs = frames_done;
        pulse();
        repeat (25) tick();
        chk("stall_valid", ray_bus.ray_valid_out, 0);
        chk("stall_hcount", ray_bus.hcount_out, 16);
        chk("stall_inflight", inflight_out, 16);
        extra_req = 1; held--;
        repeat (8) tick();
        chk("one_more_hcount", ray_bus.hcount_out, 17);
        chk("one_more_valid", ray_bus.ray_valid_out, 0);
        mode = M_FIXED; extra_req = held; held = 0;
        wait_done(fs, 1500, 0);

        // handshake and completion in the same cycle at inflight 5
        mode = M_HOLD; ray_bus.ray_ready_in = 1'b0;
        fs = frames_done;
        pulse();
        repeat (3) tick();
        ray_bus.ray_ready_in = 1'b1;
        repeat (5) tick();
        ray_bus.ray_ready_in = 1'b0;
        repeat (2) tick();
        chk("inflight5", inflight_out, 5);
        ray_bus.ray_ready_in = 1'b1; extra_req = 1; held--;
        tick();
        ray_bus.ray_ready_in = 1'b0;
        repeat (2) tick();
        chk("inflight_simul", inflight_out, 5);
        chk("hcount_after_simul", ray_bus.hcount_out, 6);
        mode = M_FIXED; extra_req = held; held = 0; ray_bus.ray_ready_in = 1'b1;
        wait_done(fs, 1000, 0);

        // new-frame pulses while busy are counted and ignored
        fs = frames_done;
        pulse();
        repeat (50) tick();
        pulse();
        repeat (100) tick();
        pulse();
        found = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (busy_out && !ray_bus.ray_valid_out && ray_bus.hcount_out == HW'(W - 1)) begin
                found = 1;
                break;
            end
        end
        chk("reached_drain", found, 1);
        pulse();
        wait_done(fs, 200, 0);
        chk("skip3", skip_count_out, 3);

        // random ready and latencies; enable dropped mid-frame
        mode = M_RAND;
        fs = frames_done;
        pulse();
        for (int i = 0; i < 200; i++) begin
            ray_bus.ray_ready_in = 1'($urandom_range(0, 1));
            tick();
        end
        enable_in = 1'b0;
        wait_done(fs, 5000, 1);
        pulse();
        repeat (5) tick();
        chk("no_start_disabled", busy_out, 0);

        // completion with nothing in flight
        ray_bus.ray_ready_in = 1'b0;
        repeat (3) tick();
        extra_req = 1;
        repeat (3) tick();
        chk("err_set", err_out, 1);
        repeat (10) tick();
        chk("err_sticky", err_out, 1);

        chk("columns_drained", colq.size(), 0);
        chk("frame_done_balance", fd_expected, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end

endmodule
